// File: rtl/e_mdu_gen.sv
// E-stage multiply/divide unit: latency-configurable multiply/MAC
// and an iterative restoring divider writing the HI/LO pair.
module e_mdu_gen #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int W2   = 2 * WIDTH;
  localparam int CMAX = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    prod;
  logic             acc_add, acc_sub;
  logic [WIDTH-1:0] q, dvs;
  logic [WIDTH:0]   rem;
  logic             neg_q, neg_r;

  logic op_mul, op_div, op_mthi, op_mtlo;
  logic op_sgn, op_add, op_sub;

  assign op_mul  = op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
  assign op_div  = op inside {4'd3, 4'd4};
  assign op_mthi = (op == 4'd5);
  assign op_mtlo = (op == 4'd6);
  assign op_sgn  = op inside {4'd1, 4'd3, 4'd7, 4'd9};
  assign op_add  = op inside {4'd7, 4'd8};
  assign op_sub  = op inside {4'd9, 4'd10};

  logic signed [W2-1:0] sa, sb, s_prod;
  logic [W2-1:0]        u_prod, prod_in;

  assign sa      = {{WIDTH{d1[WIDTH-1]}}, d1};
  assign sb      = {{WIDTH{d2[WIDTH-1]}}, d2};
  assign s_prod  = sa * sb;
  assign u_prod  = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
  assign prod_in = op_sgn ? s_prod : u_prod;

  logic [WIDTH-1:0] abs1, abs2;

  assign abs1 = (op_sgn && d1[WIDTH-1]) ? -d1 : d1;
  assign abs2 = (op_sgn && d2[WIDTH-1]) ? -d2 : d2;

  logic [W2-1:0] hl, acc_res;

  assign hl      = {hi, lo};
  assign acc_res = acc_add ? hl + prod :
                   acc_sub ? hl - prod : prod;

  // Restoring step: shift in next dividend bit, keep trial if non-negative
  logic [WIDTH:0] r_sh, r_try;
  logic           q_bit;

  assign r_sh  = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign r_try = r_sh - {1'b0, dvs};
  assign q_bit = ~r_try[WIDTH];

  logic [WIDTH-1:0] q_fix, r_fix;

  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  logic go_mul, go_div, set_dz, wr_hi, wr_lo, mul_done, fix_done;

  always_comb begin
    state_n  = state;
    go_mul   = 1'b0;
    go_div   = 1'b0;
    set_dz   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    mul_done = 1'b0;
    fix_done = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          unique case (1'b1)
            op_mul: begin
              go_mul  = 1'b1;
              state_n = MUL;
            end
            op_div: begin
              if (d2 == '0) begin
                set_dz = 1'b1;
              end else begin
                go_div  = 1'b1;
                state_n = DIV;
              end
            end
            op_mthi: wr_hi = 1'b1;
            op_mtlo: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cancel) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          mul_done = 1'b1;
          state_n  = IDLE;
        end
      end
      DIV: begin
        if (cancel) state_n = IDLE;
        else if (cnt == '0) state_n = FIX;
      end
      FIX: begin
        state_n = IDLE;
        if (!cancel) fix_done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      prod        <= '0;
      acc_add     <= 1'b0;
      acc_sub     <= 1'b0;
      q           <= '0;
      rem         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if ((state == MUL || state == DIV) && cnt != '0)
        cnt <= cnt - CW'(1);
      if (state == DIV) begin
        rem <= q_bit ? r_try : r_sh;
        q   <= {q[WIDTH-2:0], q_bit};
      end
      if (go_mul) begin
        prod    <= prod_in;
        acc_add <= op_add;
        acc_sub <= op_sub;
        cnt     <= CW'(MULT_LAT - 1);
      end
      if (go_div) begin
        q           <= abs1;
        rem         <= '0;
        dvs         <= abs2;
        neg_q       <= op_sgn & (d1[WIDTH-1] ^ d2[WIDTH-1]);
        neg_r       <= op_sgn & d1[WIDTH-1];
        div_by_zero <= 1'b0;
        cnt         <= CW'(WIDTH - 1);
      end
      if (set_dz) div_by_zero <= 1'b1;
      if (wr_hi) hi <= d1;
      if (wr_lo) lo <= d1;
      if (mul_done) {hi, lo} <= acc_res;
      if (fix_done) begin
        lo <= q_fix;
        hi <= r_fix;
      end
    end
  end

endmodule
